// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divide unit.
package div_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

  // Request attributes captured on accept and held for the whole operation.
  typedef struct packed {
    op_e             op;
    logic            quo_neg;
    logic            rem_neg;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] dividend;
  } req_t;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the EX-stage issue logic and div_unit.
interface div_if;
  import div_pkg::*;

  logic            START;
  logic [1:0]      OP;
  logic [XLEN-1:0] DIVIDEND;
  logic [XLEN-1:0] DIVISOR;
  logic            FLUSH;
  logic            BUSY;
  logic            DONE;
  logic [XLEN-1:0] RESULT;

  modport master (
    output START, OP, DIVIDEND, DIVISOR, FLUSH,
    input  BUSY, DONE, RESULT
  );

  modport slave (
    input  START, OP, DIVIDEND, DIVISOR, FLUSH,
    output BUSY, DONE, RESULT
  );

endinterface

// File: rtl/div_sign_fixup.sv
// Applies sign correction and special-case substitution to the magnitude
// quotient/remainder, then selects the value for the requested op.
module div_sign_fixup
  import div_pkg::*;
(
  input  logic [XLEN-1:0] quo_mag,
  input  logic [XLEN-1:0] rem_mag,
  input  req_t            req,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic            is_rem;

  always_comb begin
    quo    = req.quo_neg ? negate(quo_mag) : quo_mag;
    rem    = req.rem_neg ? negate(rem_mag) : rem_mag;
    is_rem = (req.op == OP_REM) || (req.op == OP_REMU);
    if (req.div_zero) begin
      quo = ALL_ONES;
      rem = req.dividend;
    end else if (req.overflow) begin
      quo = INT_MIN;
      rem = '0;
    end
    result = is_rem ? rem : quo;
  end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU) with start/done handshake.
// Build option: DIV_FAST_PATH_EN lets divide-by-zero and signed overflow skip RUN.
module div_unit
  import div_pkg::*;
(
  input logic   CLK,
  input logic   RESET,
  div_if.slave  bus
);

  state_e          state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  req_t            req_q, req_d;

  req_t            in_req;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            a_neg, b_neg, in_signed;
  logic            fast_special;

  logic [XLEN:0]   rem_shift, diff, rem_step;
  logic [XLEN-1:0] quo_step;
  logic            step_ok;

  req_t            fx_req;
  logic [XLEN-1:0] fx_quo, fx_rem, fx_result;

  // Decode of the live request operands.
  always_comb begin
    in_signed       = ~bus.OP[0];
    a_neg           = in_signed & bus.DIVIDEND[XLEN-1];
    b_neg           = in_signed & bus.DIVISOR[XLEN-1];
    a_mag           = a_neg ? negate(bus.DIVIDEND) : bus.DIVIDEND;
    b_mag           = b_neg ? negate(bus.DIVISOR) : bus.DIVISOR;
    in_req.op       = op_e'(bus.OP);
    in_req.quo_neg  = a_neg ^ b_neg;
    in_req.rem_neg  = a_neg;
    in_req.div_zero = (bus.DIVISOR == '0);
    in_req.overflow = in_signed && (bus.DIVIDEND == INT_MIN) && (bus.DIVISOR == ALL_ONES);
    in_req.dividend = bus.DIVIDEND;
  end

`ifdef DIV_FAST_PATH_EN
  assign fast_special = in_req.div_zero | in_req.overflow;
`else
  assign fast_special = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    rem_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    step_ok   = ~diff[XLEN];
    rem_step  = step_ok ? diff : rem_shift;
    quo_step  = {quo_q[XLEN-2:0], step_ok};
  end

  // Outside RUN the only result load is the fast path, which uses live inputs.
  always_comb begin
    if (state_q == RUN) begin
      fx_req = req_q;
      fx_quo = quo_step;
      fx_rem = rem_step[XLEN-1:0];
    end else begin
      fx_req = in_req;
      fx_quo = '0;
      fx_rem = '0;
    end
  end

  div_sign_fixup u_fixup (
    .quo_mag (fx_quo),
    .rem_mag (fx_rem),
    .req     (fx_req),
    .result  (fx_result)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    req_d    = req_q;
    result_d = result_q;
    if (bus.FLUSH) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, FIN: begin
          if (bus.START) begin
            req_d   = in_req;
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            count_d = '0;
            if (fast_special) begin
              state_d  = FIN;
              result_d = fx_result;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          rem_d   = rem_step;
          quo_d   = quo_step;
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_d  = FIN;
            result_d = fx_result;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      req_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      req_q    <= req_d;
      result_q <= result_d;
    end
  end

  assign bus.BUSY   = (state_q == RUN);
  assign bus.DONE   = (state_q == FIN);
  assign bus.RESULT = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit plus handshake corner sequences.
module tb_div_unit;
  import div_pkg::*;

  logic clk;
  logic reset;
  div_if bus ();

  div_unit dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  int tests;
  int fails;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.START    = 1'b1;
    bus.OP       = op;
    bus.DIVIDEND = a;
    bus.DIVISOR  = b;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive_start(op, a, b);
  endtask

  // lat counts 1 for the cycle right after the accepting edge.
  task automatic wait_done(output int lat, output logic busy_seen);
    lat = 1;
    busy_seen = 1'b0;
    while (!bus.DONE && lat < 60) begin
      if (bus.BUSY) busy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic special;
    special = (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_FAST_PATH_EN
    return special ? 1 : 33;
`else
    return (special && 1'b0) ? 1 : 33;
`endif
  endfunction

  int          lat;
  logic        busy_seen;
  logic        done_seen;
  logic [31:0] prior;
  int          elat;

  initial begin
    tests = 0;
    fails = 0;
    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    vecs[5]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1};
    vecs[6]  = '{2'b00, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF};
    vecs[7]  = '{2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678};
    vecs[8]  = '{2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9};
    vecs[9]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[10] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[11] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[12] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[13] = '{2'b11, 32'hFFFF_FFFF,  32'h10,         32'hF};
    vecs[14] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    vecs[15] = '{2'b00, 32'h8000_0000,  32'd3,          32'hD555_5556};
    vecs[16] = '{2'b10, 32'h8000_0000,  32'd3,          32'hFFFF_FFFE};

    bus.START    = 1'b0;
    bus.OP       = 2'b00;
    bus.DIVIDEND = '0;
    bus.DIVISOR  = '0;
    bus.FLUSH    = 1'b0;
    reset        = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, bus.BUSY}, 32'd0);
    check("reset_done", {31'b0, bus.DONE}, 32'd0);
    check("reset_result", bus.RESULT, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, busy_seen);
      elat = exp_latency(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_result", i), bus.RESULT, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, elat);
      check($sformatf("vec%0d_busy", i), {31'b0, busy_seen}, (elat > 1) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), {31'b0, bus.DONE}, 32'd0);
      check($sformatf("vec%0d_result_hold", i), bus.RESULT, vecs[i].exp);
    end

    // Flush mid-RUN: BUSY drops, no DONE, RESULT untouched.
    prior = bus.RESULT;
    start_op(2'b01, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.FLUSH = 1'b1;
    @(posedge clk);
    #1;
    bus.FLUSH = 1'b0;
    check("flush_busy", {31'b0, bus.BUSY}, 32'd0);
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.DONE) done_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check("flush_no_done", {31'b0, done_seen}, 32'd0);
    check("flush_result_kept", bus.RESULT, prior);

    // FLUSH together with START: nothing is accepted.
    @(negedge clk);
    bus.FLUSH = 1'b1;
    drive_start(2'b01, 32'd9, 32'd3);
    bus.FLUSH = 1'b0;
    check("flush_start_busy", {31'b0, bus.BUSY}, 32'd0);
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.DONE || bus.BUSY) done_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check("flush_start_idle", {31'b0, done_seen}, 32'd0);
    check("flush_start_result", bus.RESULT, prior);

    // START pulses during RUN are ignored.
    start_op(2'b01, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    drive_start(2'b11, 32'd200, 32'd3);
    bus.DIVIDEND = 32'd55;
    bus.DIVISOR  = 32'd5;
    wait_done(lat, busy_seen);
    check("ignore_start_result", bus.RESULT, 32'd14);
    check("ignore_start_latency", lat, 27);
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.DONE || bus.BUSY) done_seen = 1'b1;
    end
    check("ignore_start_no_second", {31'b0, done_seen}, 32'd0);

    // Back-to-back: START in the FIN cycle.
    start_op(2'b11, 32'd100, 32'd7);
    wait_done(lat, busy_seen);
    check("b2b_first_result", bus.RESULT, 32'd2);
    check("b2b_first_latency", lat, 33);
    drive_start(2'b01, 32'd1000, 32'd10);
    check("b2b_accept_busy", {31'b0, bus.BUSY}, 32'd1);
    check("b2b_first_result_held", bus.RESULT, 32'd2);
    wait_done(lat, busy_seen);
    check("b2b_second_result", bus.RESULT, 32'd100);
    check("b2b_second_latency", lat, 33);

    // Asynchronous reset mid-RUN.
    start_op(2'b01, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_result", bus.RESULT, 32'd0);
    check("async_reset_busy", {31'b0, bus.BUSY}, 32'd0);
    check("async_reset_done", {31'b0, bus.DONE}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    start_op(2'b00, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, busy_seen);
    check("post_reset_result", bus.RESULT, 32'hFFFF_FFFD);
    check("post_reset_latency", lat, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle RV32M divide unit in the EX stage. It executes DIV, DIVU, REM and REMU on the two source operands read from the register file. The result goes down the pipeline to write-back, which drives the register file write port. The unit uses an iterative radix-2 restoring algorithm and a start/done handshake that the hazard logic uses to stall the pipeline.

## Interface
- No parameters; data width fixed at 32 (package constant XLEN).
- CLK  in  1  pipeline clock; state updates on rising edge
- RESET  in  1  reset, asynchronous, active-high
- START  in  1  request; sampled on rising edge, accepted only in IDLE or FIN
- OP  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- DIVIDEND  in  32  rs1 operand (register file DATA_1 path)
- DIVISOR  in  32  rs2 operand (register file DATA_2 path)
- FLUSH  in  1  abort in-flight operation (branch mispredict/exception)
- BUSY  out  1  high while in RUN; hazard unit stalls on it
- DONE  out  1  one-cycle pulse; RESULT valid
- RESULT  out  32  quotient or remainder; held until the next DONE

## Operation
- States: IDLE, RUN, FIN.
  - IDLE/FIN + START (no FLUSH) -> RUN.
  - RUN with count==31 -> FIN.
  - FIN, no START -> IDLE.
  - Any state + FLUSH -> IDLE.
- On accept, latch the following. Later input changes are ignored.
  - OP.
  - Magnitudes |DIVIDEND| and |DIVISOR|. For DIV/REM these are two's-complement absolute values; for DIVU/REMU the raw values.
  - Quotient sign = sign(DIVIDEND) XOR sign(DIVISOR). Remainder sign = sign(DIVIDEND). Both signs are 0 for unsigned ops.
- RUN performs one restoring step per cycle, using a 33-bit partial remainder, and decrements/increments a 5-bit counter.
- FIN applies sign fixup and selects the quotient (DIV/DIVU) or remainder (REM/REMU) into RESULT. DONE=1 for exactly this cycle.
- Divisor zero:
  - Quotient = 0xFFFFFFFF for both DIV and DIVU.
  - Remainder = DIVIDEND, unmodified.
  - Sign fixup is bypassed.
- Signed overflow (DIVIDEND=0x80000000, DIVISOR=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
- START while in RUN is ignored; no queueing.
- START in the FIN cycle is accepted, giving back-to-back operations with no IDLE gap.
- FLUSH together with START: FLUSH wins, nothing is accepted. FLUSH produces no DONE and leaves RESULT unchanged.

## Timing
- Reset values: state IDLE, BUSY 0, DONE 0, RESULT 0x00000000, counter 0, internal operand registers 0.
- Latency: START sampled at edge 0. BUSY=1 from edge 0 to edge 32. DONE=1 between edges 32 and 33, so the result is available 33 cycles after START.
- RESULT updates on the same edge DONE rises. It is stable from then until the next DONE or RESET.
- RESET mid-operation immediately forces IDLE/reset values regardless of CLK.
- The register file writes on the falling edge, so write-back may consume RESULT in the DONE cycle without extra staging.

## Configuration
- DIV_FAST_PATH_EN:
  - Defined: divisor-zero and signed-overflow cases skip RUN and go IDLE/FIN -> FIN. DONE follows 1 cycle after START and BUSY never rises.
  - Undefined: every operation takes the full 32-cycle RUN. The special-case results are still substituted in FIN.
- RESULT values are identical in both builds; only latency differs.

## Structure
- Shared package (div_pkg):
  - XLEN=32.
  - OP encodings: DIV, DIVU, REM, REMU.
  - State enum: IDLE/RUN/FIN.
  - Constants: INT_MIN=0x80000000, ALL_ONES=0xFFFFFFFF.
- One sub-module is natural: div_sign_fixup, combinational. It takes the magnitude quotient/remainder, the latched signs and the special-case flags, and returns the final RESULT. The FSM and iteration stay in div_unit.

## Test plan
- DIVU 100/7 -> RESULT 14, DONE exactly 33 cycles after START; REMU same operands -> 2.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3); REM -> 0xFFFFFFFF(-1); DIV 7/0xFFFFFFFE(-2) -> 0xFFFFFFFD.
- DIV 0x12345678/0 -> 0xFFFFFFFF; REMU 0x12345678/0 -> 0x12345678; with DIV_FAST_PATH_EN, DONE 1 cycle after START and BUSY stays 0.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU same operands -> 0x00000000.
- FLUSH 10 cycles after START:
  - BUSY low next edge, no DONE, RESULT keeps its prior value.
  - RESET asserted mid-RUN -> RESULT 0, IDLE without a clock edge.
- START pulses during RUN are ignored, so the result matches the first operands.
- START in the FIN cycle with new operands is accepted and yields a second DONE 33 cycles later.
